// File: rtl/sev_segmonitor.sv
// Receive-side monitor for a multiplexed, active-low 7-segment scan bus.
// Qualifies each scan slot for stability and decodes it back into {dp, hex} per digit.
module sev_segmonitor #(
    parameter int STABLE_CNT = 2,
    parameter int TIMEOUT    = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] seg_in,
    input  logic       dp_in,
    input  logic [3:0] anode_in,
    output logic [4:0] digit0,
    output logic [4:0] digit1,
    output logic [4:0] digit2,
    output logic [4:0] digit3,
    output logic [3:0] digit_valid,
    output logic [3:0] pattern_err,
    output logic       anode_err,
    output logic       frame_done,
    output logic       stale
);

    localparam logic [3:0]  SC = 4'(STABLE_CNT);
    localparam logic [15:0] TO = 16'(TIMEOUT);

    // Returns {match, hex}; match=0 for any pattern outside the 16 glyphs.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'b1000000: return {1'b1, 4'h0};
            7'b1111001: return {1'b1, 4'h1};
            7'b0100100: return {1'b1, 4'h2};
            7'b0110000: return {1'b1, 4'h3};
            7'b0011001: return {1'b1, 4'h4};
            7'b0010010: return {1'b1, 4'h5};
            7'b0000010: return {1'b1, 4'h6};
            7'b1111000: return {1'b1, 4'h7};
            7'b0000000: return {1'b1, 4'h8};
            7'b0010000: return {1'b1, 4'h9};
            7'b0001000: return {1'b1, 4'hA};
            7'b0000011: return {1'b1, 4'hB};
            7'b1000110: return {1'b1, 4'hC};
            7'b0100001: return {1'b1, 4'hD};
            7'b0000110: return {1'b1, 4'hE};
            7'b0001110: return {1'b1, 4'hF};
            default:    return 5'b0_0000;
        endcase
    endfunction

    function automatic logic [1:0] anode_index(input logic [3:0] sel);
        case (sel)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Synchronizer word layout: {anode[3:0], dp, seg[6:0]}
    logic [11:0] s1, s2;
    logic [3:0]  cnt, cnt_next;
    logic        changed, qualify;
    logic [3:0]  sel;
    logic        single, multi, capture;
    logic [1:0]  idx;
    logic [4:0]  dec;
    logic        blank_seg;
    logic [3:0]  seen, seen_set;
    logic [15:0] tcnt;
    logic [4:0]  digits [4];

    // s1 is the value s2 takes on this edge, so qualification looks at s1.
    always_comb begin
        changed = (s1 != s2);
        if (changed)
            cnt_next = 4'd1;
        else if (cnt == SC)
            cnt_next = cnt;
        else
            cnt_next = cnt + 4'd1;
        qualify   = (cnt_next == SC) && (changed || (cnt != SC));
        sel       = ~s1[11:8];
        single    = $onehot(sel);
        multi     = !$onehot0(sel);
        capture   = qualify && single;
        idx       = anode_index(sel);
        dec       = decode_seg(s1[6:0]);
        blank_seg = (s1[6:0] == 7'h7F);
        seen_set  = seen | (4'b0001 << idx);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1          <= '1;
            s2          <= '1;
            cnt         <= '0;
            seen        <= '0;
            tcnt        <= '0;
            digit_valid <= '0;
            pattern_err <= '0;
            anode_err   <= 1'b0;
            frame_done  <= 1'b0;
            stale       <= 1'b0;
            for (int i = 0; i < 4; i++) digits[i] <= '0;
        end else begin
            s1         <= {anode_in, dp_in, seg_in};
            s2         <= s1;
            cnt        <= cnt_next;
            anode_err  <= 1'b0;
            frame_done <= 1'b0;
            if (capture) begin
                digits[idx][4] <= s1[7];
                if (dec[4]) begin
                    digits[idx][3:0] <= dec[3:0];
                    digit_valid[idx] <= 1'b1;
                    pattern_err[idx] <= 1'b0;
                end else if (blank_seg) begin
                    digits[idx][3:0] <= 4'h0;
                    digit_valid[idx] <= 1'b0;
                    pattern_err[idx] <= 1'b0;
                end else begin
                    digit_valid[idx] <= 1'b0;
                    pattern_err[idx] <= 1'b1;
                end
                if (seen_set == 4'b1111) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen_set;
                end
                tcnt  <= '0;
                stale <= 1'b0;
            end else begin
                if (qualify && multi) anode_err <= 1'b1;
                // Counter parks at TIMEOUT; the stale side effects happen once on arrival.
                if (tcnt != TO) begin
                    tcnt <= tcnt + 16'd1;
                    if (tcnt + 16'd1 == TO) begin
                        stale       <= 1'b1;
                        digit_valid <= '0;
                        seen        <= '0;
                    end
                end
            end
        end
    end

    assign digit0 = digits[0];
    assign digit1 = digits[1];
    assign digit2 = digits[2];
    assign digit3 = digits[3];

endmodule

// File: tb/tb_sev_segmonitor.sv
// Randomized and directed bench for sev_segmonitor against a behavioural model
// built from run lengths, a glyph table search and an idle-cycle count.
module tb_sev_segmonitor;

    localparam int SC = 2;
    localparam int TO = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       dp_in;
    logic [3:0] anode_in;
    logic [4:0] digit0, digit1, digit2, digit3;
    logic [3:0] digit_valid, pattern_err;
    logic       anode_err, frame_done, stale;

    sev_segmonitor #(.STABLE_CNT(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dp_in(dp_in), .anode_in(anode_in),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .digit_valid(digit_valid), .pattern_err(pattern_err),
        .anode_err(anode_err), .frame_done(frame_done), .stale(stale)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state
    logic [11:0] q1, q2;
    int          run;
    logic [4:0]  m_dig [4];
    logic [3:0]  m_val, m_err, m_seen;
    logic        m_ae, m_fd, m_stale;
    int          idle;
    int          fd_obs, ae_obs;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [31:0] dut_word();
        return {digit3, digit2, digit1, digit0, digit_valid, pattern_err, anode_err, frame_done, stale};
    endfunction

    function automatic logic [31:0] model_word();
        return {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_val, m_err, m_ae, m_fd, m_stale};
    endfunction

    task automatic model_reset();
        q1 = '1; q2 = '1; run = 0;
        for (int i = 0; i < 4; i++) m_dig[i] = '0;
        m_val = '0; m_err = '0; m_seen = '0;
        m_ae = 0; m_fd = 0; m_stale = 0; idle = 0;
    endtask

    task automatic model_edge();
        logic [3:0] a;
        logic [6:0] s;
        logic       d, cap, found;
        int         zeros, dig;
        logic [3:0] hx;
        if (q1 != q2) run = 1; else run = run + 1;
        q2 = q1;
        q1 = {anode_in, dp_in, seg_in};
        m_ae = 0; m_fd = 0; cap = 0; dig = 0;
        a = q2[11:8]; d = q2[7]; s = q2[6:0];
        if (run == SC) begin
            zeros = 0;
            for (int i = 0; i < 4; i++) if (!a[i]) begin zeros++; dig = i; end
            if (zeros == 1) cap = 1;
            else if (zeros >= 2) m_ae = 1;
        end
        if (cap) begin
            found = 0; hx = 0;
            for (int h = 0; h < 16; h++) if (hex2seg(4'(h)) == s) begin found = 1; hx = 4'(h); end
            m_dig[dig][4] = d;
            if (found) begin m_dig[dig][3:0] = hx; m_val[dig] = 1; m_err[dig] = 0; end
            else if (s == 7'h7F) begin m_dig[dig][3:0] = 0; m_val[dig] = 0; m_err[dig] = 0; end
            else begin m_val[dig] = 0; m_err[dig] = 1; end
            m_seen[dig] = 1;
            if (m_seen == 4'hF) begin m_fd = 1; m_seen = 0; end
            idle = 0; m_stale = 0;
        end else begin
            idle++;
            if (idle == TO) begin m_stale = 1; m_val = 0; m_seen = 0; end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset(); else model_edge();
        #1;
        if (frame_done) fd_obs++;
        if (anode_err) ae_obs++;
    endtask

    task automatic hold_slot(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        anode_in = a; seg_in = s; dp_in = d;
        repeat (n) step();
    endtask

    task automatic test_reset();
        rst = 1; anode_in = 4'hF; seg_in = 7'h7F; dp_in = 1;
        model_reset();
        repeat (3) step();
        checks++;
        if ({digit3, digit2, digit1, digit0} !== 20'h0) begin
            failures++; $display("FAIL reset_digits got=%h want=0", {digit3, digit2, digit1, digit0});
        end
        checks++;
        if ({digit_valid, pattern_err} !== 8'h0) begin
            failures++; $display("FAIL reset_flags got=%h want=0", {digit_valid, pattern_err});
        end
        checks++;
        if ({anode_err, frame_done, stale} !== 3'b000) begin
            failures++; $display("FAIL reset_pulses got=%b want=000", {anode_err, frame_done, stale});
        end
        rst = 0;
        repeat (3) step();
    endtask

    task automatic test_loopback();
        logic [3:0] vals [4];
        int f0;
        vals[0] = 4'h1; vals[1] = 4'h2; vals[2] = 4'h3; vals[3] = 4'hA;
        f0 = fd_obs;
        for (int fr = 0; fr < 3; fr++) begin
            for (int i = 0; i < 4; i++) begin
                anode_in = ~(4'b0001 << i); seg_in = hex2seg(vals[i]); dp_in = 0;
                for (int c = 0; c < 4; c++) begin
                    step();
                    checks++;
                    if (dut_word() !== model_word()) begin
                        failures++; $display("FAIL loopback_cycle got=%h want=%h", dut_word(), model_word());
                    end
                end
            end
        end
        hold_slot(4'hF, 7'h7F, 0, 4);
        checks++;
        if ({digit3, digit2, digit1, digit0} !== {5'h0A, 5'h03, 5'h02, 5'h01} || digit_valid !== 4'hF) begin
            failures++; $display("FAIL loopback_digits got=%h/%h want=%h/f",
                                 {digit3, digit2, digit1, digit0}, digit_valid, {5'h0A, 5'h03, 5'h02, 5'h01});
        end
        checks++;
        if (fd_obs - f0 !== 3) begin
            failures++; $display("FAIL loopback_frames got=%0d want=3", fd_obs - f0);
        end
    endtask

    task automatic test_hold();
        anode_in = 4'b1110; seg_in = 7'b0010010; dp_in = 1;
        step(); step();
        checks++;
        if (digit0 !== 5'h01) begin
            failures++; $display("FAIL hold_before_e2 got=%h want=01", digit0);
        end
        step();
        checks++;
        if (digit0 !== 5'h15 || digit_valid[0] !== 1'b1) begin
            failures++; $display("FAIL hold_at_e2 got=%h/%b want=15/1", digit0, digit_valid[0]);
        end
        for (int c = 0; c < 8; c++) begin
            step();
            checks++;
            if (dut_word() !== model_word() || digit0 !== 5'h15) begin
                failures++; $display("FAIL hold_steady got=%h want=%h", dut_word(), model_word());
            end
        end
    endtask

    task automatic test_glitch();
        hold_slot(4'b1101, hex2seg(4'h5), 0, 5);
        for (int c = 0; c < 6; c++) begin
            seg_in = (c == 0) ? 7'b0000000 : hex2seg(4'h5);
            step();
            checks++;
            if (dut_word() !== model_word() || digit1 !== 5'h05) begin
                failures++; $display("FAIL glitch got=%h digit1=%h want=%h digit1=05",
                                     dut_word(), digit1, model_word());
            end
        end
    endtask

    task automatic test_anode_err();
        int a0;
        a0 = ae_obs;
        hold_slot(4'b1100, hex2seg(4'h8), 0, 6);
        checks++;
        if (ae_obs - a0 !== 1) begin
            failures++; $display("FAIL anode_err_pulses got=%0d want=1", ae_obs - a0);
        end
        hold_slot(4'b0111, 7'b1010101, 0, 4);
        checks++;
        if (pattern_err[3] !== 1'b1 || digit_valid[3] !== 1'b0 || digit3 !== 5'h0A) begin
            failures++; $display("FAIL pattern_err got=%b/%b/%h want=1/0/0a",
                                 pattern_err[3], digit_valid[3], digit3);
        end
        checks++;
        if (dut_word() !== model_word()) begin
            failures++; $display("FAIL pattern_err_model got=%h want=%h", dut_word(), model_word());
        end
    endtask

    task automatic test_timeout();
        anode_in = 4'hF; seg_in = 7'h7F; dp_in = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            checks++;
            if (stale !== m_stale || digit_valid !== m_val) begin
                failures++; $display("FAIL timeout_cycle%0d got=%b/%h want=%b/%h",
                                     c, stale, digit_valid, m_stale, m_val);
            end
        end
        checks++;
        if (stale !== 1'b1 || digit_valid !== 4'h0 || digit0 !== 5'h15) begin
            failures++; $display("FAIL timeout_end got=%b/%h/%h want=1/0/15", stale, digit_valid, digit0);
        end
        hold_slot(4'b1101, hex2seg(4'h7), 0, 4);
        checks++;
        if (stale !== 1'b0 || digit_valid !== 4'b0010 || digit1 !== 5'h07) begin
            failures++; $display("FAIL timeout_recover got=%b/%h/%h want=0/2/07", stale, digit_valid, digit1);
        end
    endtask

    task automatic test_reset_midframe();
        int f0;
        hold_slot(4'hF, 7'h7F, 0, 4);
        hold_slot(4'b1110, hex2seg(4'h3), 0, 4);
        hold_slot(4'b1101, hex2seg(4'h4), 0, 4);
        rst = 1;
        model_reset();
        #2;
        checks++;
        if (dut_word() !== 32'h0) begin
            failures++; $display("FAIL midframe_reset got=%h want=0", dut_word());
        end
        step();
        rst = 0;
        f0 = fd_obs;
        hold_slot(4'b1011, hex2seg(4'h2), 0, 4);
        hold_slot(4'b0111, hex2seg(4'h3), 0, 4);
        hold_slot(4'b1110, hex2seg(4'h0), 0, 4);
        checks++;
        if (fd_obs - f0 !== 0) begin
            failures++; $display("FAIL midframe_early_frame got=%0d want=0", fd_obs - f0);
        end
        hold_slot(4'b1101, hex2seg(4'h1), 0, 4);
        checks++;
        if (fd_obs - f0 !== 1) begin
            failures++; $display("FAIL midframe_frame got=%0d want=1", fd_obs - f0);
        end
        checks++;
        if (dut_word() !== model_word()) begin
            failures++; $display("FAIL midframe_state got=%h want=%h", dut_word(), model_word());
        end
    endtask

    task automatic test_random();
        int r, n;
        for (int k = 0; k < 400; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      anode_in = ~(4'b0001 << $urandom_range(0, 3));
            else if (r == 8) anode_in = 4'($urandom);
            else             anode_in = 4'hF;
            r = $urandom_range(0, 9);
            if (r <= 6)      seg_in = hex2seg(4'($urandom));
            else if (r == 7) seg_in = 7'h7F;
            else             seg_in = 7'($urandom);
            dp_in = 1'($urandom);
            n = $urandom_range(1, 5);
            if (anode_in == 4'hF && $urandom_range(0, 15) == 0) n = 70;
            for (int c = 0; c < n; c++) begin
                step();
                checks++;
                if (dut_word() !== model_word()) begin
                    failures++; $display("FAIL random_k%0d got=%h want=%h", k, dut_word(), model_word());
                end
            end
        end
    endtask

    initial begin
        fd_obs = 0; ae_obs = 0;
        test_reset();
        test_loopback();
        test_hold();
        test_glitch();
        test_anode_err();
        test_timeout();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
